// File: rtl/spi_xfer_scheduler.sv
// SPI transaction scheduler: round-robin arbitration between requesters,
// chip-select ownership with setup/hold/gap timing, and streaming of the
// granted requester's words to/from the core FIFOs.
module spi_xfer_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int NUM_CS   = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*$clog2(NUM_CS)-1:0]    req_cs,
  input  logic [NUM_REQ*8-1:0]                 req_len,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   done,
  output logic [NUM_REQ-1:0]                   abort,
  input  logic [NUM_REQ*32-1:0]                tx_data,
  input  logic [NUM_REQ-1:0]                   tx_valid,
  output logic [NUM_REQ-1:0]                   tx_ready,
  output logic [31:0]                          rx_data,
  output logic [NUM_REQ-1:0]                   rx_valid,
  input  logic [NUM_REQ-1:0]                   rx_ready,
  output logic [NUM_CS-1:0]                    cs_n,
  output logic                                 core_enable,
  output logic [31:0]                          core_tx_data,
  output logic                                 core_tx_push,
  input  logic                                 core_tx_full,
  input  logic [31:0]                          core_rx_data,
  output logic                                 core_rx_pop,
  input  logic                                 core_rx_empty,
  input  logic                                 core_busy
);

  // state  | meaning
  // IDLE   | waiting for en and a request; arbitrates on grant
  // SETUP  | cs_n low, waiting CS_SETUP cycles before first push
  // STREAM | moving words between requester and core FIFOs
  // HOLD   | all words back, cs_n held low for CS_HOLD cycles
  // GAP    | cs_n high for CS_GAP cycles before next arbitration
  // FLUSH  | aborted: core disabled for one cycle to drain its FIFOs
  typedef enum logic [2:0] {IDLE, SETUP, STREAM, HOLD, GAP, FLUSH} state_t;

  localparam int CSW = $clog2(NUM_CS);
  localparam int GW  = $clog2(NUM_REQ);

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   g_idx;
  logic [8:0]      len;
  logic [8:0]      tx_cnt;
  logic [8:0]      rx_cnt;
  logic [15:0]     tmr;

  logic               win_found;
  logic [GW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [CSW-1:0]     win_cs;
  logic [7:0]         win_len;
  logic [NUM_CS-1:0]  win_cs_n;
  logic [GW-1:0]      rr_next;
  logic               in_stream;
  logic               tx_ok;
  logic               rx_ok;

  // Round-robin search for the first active request starting at rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  assign win_cs  = req_cs[win_idx*CSW +: CSW];
  assign win_len = req_len[win_idx*8 +: 8];
  assign rr_next = (g_idx == GW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

  // Decode winner's chip select; an out-of-range index selects nothing.
  always_comb begin
    win_cs_n = '1;
    win_oh   = '0;
    win_oh[win_idx] = 1'b1;
    for (int c = 0; c < NUM_CS; c++) begin
      if (CSW'(c) == win_cs) win_cs_n[c] = 1'b0;
    end
  end

  assign in_stream    = (state == STREAM);
  assign tx_ok        = in_stream && (tx_cnt < len) && !core_tx_full;
  assign rx_ok        = in_stream && !core_rx_empty;
  assign core_tx_push = tx_ok && tx_valid[g_idx];
  assign core_rx_pop  = rx_ok && rx_ready[g_idx];
  assign core_tx_data = tx_data[g_idx*32 +: 32];
  assign rx_data      = in_stream ? core_rx_data : '0;

  // Steer the handshakes to the granted requester only.
  always_comb begin
    tx_ready = '0;
    rx_valid = '0;
    tx_ready[g_idx] = tx_ok;
    rx_valid[g_idx] = rx_ok;
  end

  // Transaction FSM with registered grant, chip selects and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      g_idx       <= '0;
      gnt         <= '0;
      done        <= '0;
      abort       <= '0;
      cs_n        <= '1;
      core_enable <= 1'b0;
      len         <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      tmr         <= '0;
    end else begin
      done        <= '0;
      abort       <= '0;
      core_enable <= en;
      if (core_tx_push) tx_cnt <= tx_cnt + 9'd1;
      if (core_rx_pop)  rx_cnt <= rx_cnt + 9'd1;
      case (state)
        IDLE: begin
          if (en && win_found) begin
            g_idx  <= win_idx;
            gnt    <= win_oh;
            cs_n   <= win_cs_n;
            len    <= (win_len == 8'd0) ? 9'd256 : {1'b0, win_len};
            tx_cnt <= '0;
            rx_cnt <= '0;
            tmr    <= 16'(CS_SETUP - 1);
            state  <= SETUP;
          end
        end
        SETUP, STREAM, HOLD: begin
          if (!en) begin
            // Deselect immediately and keep the core disabled for one cycle.
            state        <= FLUSH;
            cs_n         <= '1;
            gnt          <= '0;
            abort[g_idx] <= 1'b1;
            rr_ptr       <= rr_next;
            core_enable  <= 1'b0;
          end else if (state == SETUP) begin
            if (tmr == 16'd0) state <= STREAM;
            else              tmr   <= tmr - 16'd1;
          end else if (state == STREAM) begin
            if (rx_cnt == len && !core_busy) begin
              tmr   <= 16'(CS_HOLD - 1);
              state <= HOLD;
            end
          end else begin
            if (tmr == 16'd0) begin
              cs_n        <= '1;
              gnt         <= '0;
              done[g_idx] <= 1'b1;
              rr_ptr      <= rr_next;
              tmr         <= 16'(CS_GAP - 1);
              state       <= GAP;
            end else begin
              tmr <= tmr - 16'd1;
            end
          end
        end
        GAP: begin
          if (tmr == 16'd0) state <= IDLE;
          else              tmr   <= tmr - 16'd1;
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_xfer_scheduler.md
# spi_xfer_scheduler

Transaction scheduler for the SPI master core: arbitrates between NUM_REQ requesters, owns the chip-select lines, and streams each granted requester's words into the core TX FIFO while returning core RX words to the same requester. Each transaction is one chip-select assertion with programmable setup, hold and inter-transaction gap. Sits between the bus-side register wrappers (or DMA channels) and the core's FIFO ports.

## Interface
- NUM_REQ, 2: number of requesters (2..8)
- NUM_CS, 4: number of chip-select lines (2..16)
- CS_SETUP, 2: cycles from cs_n assertion to the first TX push (min 1)
- CS_HOLD, 2: cycles cs_n stays low after the last RX word and core idle (min 1)
- CS_GAP, 4: cycles cs_n stays high before the next grant (min 1)
- clk in 1: clock
- rst_n in 1: reset, asynchronous, active-low
- en in 1: scheduler enable; low aborts the current transaction
- req in NUM_REQ: transaction request, level, held until done
- req_cs in NUM_REQ*CSW: per-requester chip-select index, CSW=$clog2(NUM_CS)
- req_len in NUM_REQ*8: per-requester word count; 0 means 256
- gnt out NUM_REQ: one-hot grant, held for the whole transaction
- done out NUM_REQ: one-cycle completion pulse
- abort out NUM_REQ: one-cycle pulse, transaction killed by en low
- tx_data in NUM_REQ*32: per-requester TX word
- tx_valid in NUM_REQ: TX word valid
- tx_ready out NUM_REQ: TX accept; only the granted bit can be high
- rx_data out 32: RX word, shared
- rx_valid out NUM_REQ: RX valid; only the granted bit can be high
- rx_ready in NUM_REQ: RX accept
- cs_n out NUM_CS: active-low chip selects
- core_enable out 1: drives the core enable input
- core_tx_data out 32, core_tx_push out 1, core_tx_full in 1: core TX FIFO port
- core_rx_data in 32, core_rx_pop out 1, core_rx_empty in 1: core RX FIFO port (FWFT)
- core_busy in 1: core busy status

## Operation
- States: IDLE, SETUP, STREAM, HOLD, GAP, FLUSH.
- IDLE: if en and any req, pick the winner round-robin starting at rr_ptr. Register gnt, latch cs index and length (9-bit, 0 becomes 256), clear tx_cnt and rx_cnt. Drive cs_n[cs] low and go to SETUP.
- SETUP: count CS_SETUP cycles, then go to STREAM.
- STREAM:
  - tx_ready[g] = (tx_cnt < len) && !core_tx_full.
  - core_tx_push = tx_valid[g] && tx_ready[g], combinational. core_tx_data = tx_data[g]. tx_cnt increments on each push.
  - rx_valid[g] = !core_rx_empty. rx_data = core_rx_data.
  - core_rx_pop = rx_valid[g] && rx_ready[g]. rx_cnt increments on each pop.
  - Leave to HOLD when rx_cnt == len and !core_busy.
- HOLD: cs_n stays low for CS_HOLD cycles. On exit: cs_n goes high, done[g] pulses, gnt clears, rr_ptr moves to g+1 (mod NUM_REQ), go to GAP.
- GAP: all cs_n high for CS_GAP cycles, then IDLE.
- Abort: en low in SETUP, STREAM or HOLD sends the FSM to FLUSH.
  - In FLUSH: cs_n goes high the same cycle, core_enable is low for exactly 1 cycle (flushes both core FIFOs), abort[g] pulses, gnt clears. Then go to IDLE; rr_ptr still advances.
  - core_enable = en in all other states.
- At most one cs_n is low at any time. cs_n is registered and glitch-free.
- A req_cs index >= NUM_CS is treated as "no chip select": the transfer runs with all cs_n high.
- Pushes and pops are independent and can occur in the same cycle.
- The RX path tolerates a stalled rx_ready; the core RX FIFO provides backpressure.

## Timing
- Reset values: state IDLE, rr_ptr 0, cs_n all 1, gnt 0, done 0, abort 0, tx_ready 0, rx_valid 0, core_tx_push 0, core_rx_pop 0, core_enable 0, rx_data 0.
- Reset asserted mid-transaction: cs_n goes high asynchronously.
- Grant latency: req sampled high in IDLE gives gnt and cs_n low on the next edge.
- First core_tx_push possible CS_SETUP cycles after cs_n falls.
- done pulses CS_HOLD cycles after the cycle where rx_cnt==len && !core_busy is first true. cs_n rises on the same edge as done.
- Minimum cs_n-high time between transactions: CS_GAP+1 cycles.
- Requester and core handshake signals are valid/ready: a transfer occurs only in a cycle where both are high. Data must be stable while valid is high.

## Test plan
- Single transfer: req0, cs=1, len=3, words 0xA5/0x3C/0xFF, loopback core -> cs_n[1] low throughout, 3 pushes and 3 pops, rx returns 0xA5/0x3C/0xFF, done[0] pulses once, cs_n[1] high after CS_HOLD cycles.
- Fairness: req0 and req1 held high continuously, len=1 each -> grants alternate 0,1,0,1; cs_n high for ≥CS_GAP+1 cycles between grants.
- Backpressure: len=20 with core FIFO depth 16, rx_ready low for 50 cycles -> tx_ready drops while core_tx_full; all 20 words returned in order; no loss or duplication.
- Abort: en dropped after 2 of 5 words -> cs_n high on the next edge, core_enable low for exactly 1 cycle, abort[g] pulses, done does not pulse, next requester is served normally.
- len=0: 256 words pushed and popped, done pulses once, tx_cnt/rx_cnt do not wrap early.
- Reset mid-STREAM -> all outputs return to their reset values; a new request after reset completes normally.
